// File: rtl/burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// burst_rr_arbiter
//
// Round-robin arbiter that gives a burst to one requester at a time. Each
// requester is a first-word-fall-through FIFO.
//
// Arbitration:
// - IDLE takes one cycle. It picks the next eligible requester (WRITE_REQ &
//   ENABLE), searching cyclically from the one after the previous owner.
// - BURST moves one word per cycle while the owner's FIFO is non-empty and
//   READY_OUT is high.
// - The owner keeps the grant while HOLD_REQ is high. Otherwise the grant ends
//   when its FIFO runs dry or after MAX_BURST words.
// - Dropping ENABLE for the owner ends the grant at once, with no transfer.
//
// Optional feature (macro BURST_ARB_STALL_CNT_EN):
// - adds the STALL_CNT output, a saturating count of owner-stalled cycles.
//
// Parameters:
//   WIDTH     number of requesters
//   DSIZE     data word width
//   MAX_BURST words per grant when not held (1..255)
//
// Ports:
//   BUS_CLK     clock, rising edge
//   BUS_RST_N   asynchronous active-low reset
//   ENABLE      per-requester arbitration enable
//   WRITE_REQ   per-requester FIFO not empty
//   HOLD_REQ    per-requester request to keep the grant
//   DATA_IN     requester k word at [k*DSIZE +: DSIZE]
//   READY_OUT   downstream accepts a word this cycle
//   READ_GRANT  pop strobe to the owner FIFO (one-hot or zero)
//   WRITE_OUT   word valid to downstream
//   DATA_OUT    owner's word while BUSY, else zero
//   GRANT_ID    owner index (meaningful while BUSY)
//   STALL_CNT   stalled-cycle counter (only with BURST_ARB_STALL_CNT_EN)
//   BUSY        high while a grant is active
// -----------------------------------------------------------------------------
module burst_rr_arbiter #(
  parameter int WIDTH     = 5,
  parameter int DSIZE     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST_N,
  input  logic [WIDTH-1:0]       ENABLE,
  input  logic [WIDTH-1:0]       WRITE_REQ,
  input  logic [WIDTH-1:0]       HOLD_REQ,
  input  logic [WIDTH*DSIZE-1:0] DATA_IN,
  input  logic                   READY_OUT,
  output logic [WIDTH-1:0]       READ_GRANT,
  output logic                   WRITE_OUT,
  output logic [DSIZE-1:0]       DATA_OUT,
  output logic [7:0]             GRANT_ID,
`ifdef BURST_ARB_STALL_CNT_EN
  output logic [31:0]            STALL_CNT,
`endif
  output logic                   BUSY
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [SW-1:0] LAST_RST = SW'(WIDTH - 1);
  localparam logic [7:0]    MAX_CNT  = 8'(MAX_BURST);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q,   sel_d;
  logic [SW-1:0] last_q,  last_d;
  logic [7:0]    cnt_q,   cnt_d;

  logic [DSIZE-1:0] data_arr [WIDTH];
  logic [SW-1:0]    cand_idx [WIDTH];
  logic [WIDTH-1:0] eligible;
  logic [WIDTH-1:0] rot_req;
  logic [SW-1:0]    pick_idx;

  logic       busy;
  logic       sel_req;
  logic       sel_en;
  logic       sel_hold;
  logic       xfer;
  logic [7:0] cnt_inc;

  assign eligible = WRITE_REQ & ENABLE;

  // cand_idx[gi] is the requester visited gi+1 places after the last owner.
  // It is (last_q + gi + 1) mod WIDTH, computed without a wider adder.
  // rot_req is the eligible mask in search order.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign data_arr[gi] = DATA_IN[gi*DSIZE +: DSIZE];

    assign cand_idx[gi] = (last_q >= SW'(WIDTH - 1 - gi)) ?
                          last_q - SW'(WIDTH - 1 - gi) :
                          last_q + SW'(gi + 1);

    assign rot_req[gi] = eligible[cand_idx[gi]];

    assign READ_GRANT[gi] = xfer && (sel_q == SW'(gi));
  end

  // Pick the earliest eligible position in search order.
  // Scanning down means the lowest set position is written last and wins.
  always_comb begin
    pick_idx = '0;
    for (int j = WIDTH - 1; j >= 0; j--) begin
      if (rot_req[j]) begin
        pick_idx = cand_idx[j];
      end
    end
  end

  assign busy     = (state_q == ST_BURST);
  assign sel_req  = WRITE_REQ[sel_q];
  assign sel_en   = ENABLE[sel_q];
  assign sel_hold = HOLD_REQ[sel_q];

  // A disabled owner never transfers, even if its FIFO and downstream are ready.
  assign xfer = busy && sel_en && sel_req && READY_OUT;

  // Burst length including this cycle's transfer.
  // It saturates so that a long held burst cannot wrap the counter.
  assign cnt_inc = (xfer && (cnt_q < MAX_CNT)) ? cnt_q + 8'd1 : cnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          sel_d   = pick_idx;
          cnt_d   = 8'd0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        cnt_d = cnt_inc;
        // Disable beats hold.
        // Otherwise hold keeps the grant past an empty FIFO or a full burst.
        if (!sel_en || (!sel_hold && (!sel_req || (cnt_inc >= MAX_CNT)))) begin
          state_d = ST_IDLE;
          last_d  = sel_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY      = busy;
  assign WRITE_OUT = xfer;
  assign GRANT_ID  = 8'(sel_q);
  assign DATA_OUT  = busy ? data_arr[sel_q] : '0;

`ifdef BURST_ARB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Counts cycles where the owner has data but downstream is not ready.
  always_comb begin
    stall_d = stall_q;
    if (busy && sel_req && !READY_OUT && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_burst_rr_arbiter
//
// Directed and random stimulus for burst_rr_arbiter with WIDTH=5, DSIZE=32
// and MAX_BURST=4.
//
// Bench structure:
// - Requester FIFOs are modelled as small arrays. Word j pushed to requester k
//   has the value k*1000 + j.
// - A negedge process compares the DUT against a grant-level model every
//   cycle. The model tracks owner, last owner, words granted and stall count.
// - After each scenario, logged transfers are compared with hand-derived
//   cycle, owner and data values.
// -----------------------------------------------------------------------------
module tb_burst_rr_arbiter;

  localparam int W  = 5;
  localparam int DS = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    enable;
  logic [W-1:0]    write_req;
  logic [W-1:0]    hold_req;
  logic [W*DS-1:0] data_in;
  logic            ready_out;
  logic [W-1:0]    read_grant;
  logic            write_out;
  logic [DS-1:0]   data_out;
  logic [7:0]      grant_id;
  logic            busy;
  logic [31:0]     stall_cnt;

  always #5 clk = ~clk;

  burst_rr_arbiter #(.WIDTH(W), .DSIZE(DS), .MAX_BURST(MB)) dut (
    .BUS_CLK    (clk),
    .BUS_RST_N  (rst_n),
    .ENABLE     (enable),
    .WRITE_REQ  (write_req),
    .HOLD_REQ   (hold_req),
    .DATA_IN    (data_in),
    .READY_OUT  (ready_out),
    .READ_GRANT (read_grant),
    .WRITE_OUT  (write_out),
    .DATA_OUT   (data_out),
    .GRANT_ID   (grant_id),
`ifdef BURST_ARB_STALL_CNT_EN
    .STALL_CNT  (stall_cnt),
`endif
    .BUSY       (busy)
  );

`ifndef BURST_ARB_STALL_CNT_EN
  assign stall_cnt = 32'd0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  // Requester FIFOs.
  logic [31:0] fmem [W][64];
  int          fhead [W];
  int          ftail [W];
  logic [W-1:0] pop_mask = '0;
  bit          fifo_mode = 1'b1;

  // Transfer log for the directed scenarios.
  bit          log_en = 1'b0;
  int          n_tr = 0;
  int          tr_cyc [64];
  int          tr_id  [64];
  logic [31:0] tr_dat [64];
  int          busy_seen = 0;

  // Model state.
  bit          m_busy = 1'b0;
  int          m_owner = 0;
  int          m_last = W - 1;
  int          m_words = 0;
  logic [31:0] m_stall = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  // Compare process: DUT outputs against the model, once per cycle.
  always @(negedge clk) begin
    logic [W-1:0]  e_grant;
    logic          e_xfer;
    logic [DS-1:0] e_data;
    if (!rst_n) begin
      chk("rst_grant", read_grant, 0);
      chk("rst_wout",  write_out, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_gid",   grant_id, 0);
      chk("rst_data",  data_out, 0);
      chk("rst_stall", stall_cnt, 0);
      m_busy  = 1'b0;
      m_last  = W - 1;
      m_words = 0;
      m_stall = 32'd0;
    end else begin
      e_grant = '0;
      e_xfer  = 1'b0;
      e_data  = '0;
      if (m_busy) begin
        e_xfer = enable[m_owner] && write_req[m_owner] && ready_out;
        e_data = data_in[m_owner*DS +: DS];
        if (e_xfer) e_grant[m_owner] = 1'b1;
        chk("gid", grant_id, m_owner);
      end
      chk("busy",  busy, m_busy);
      chk("grant", read_grant, e_grant);
      chk("wout",  write_out, e_xfer);
      chk("data",  data_out, e_data);
`ifdef BURST_ARB_STALL_CNT_EN
      chk("stall", stall_cnt, m_stall);
`endif
      chk("onehot", 64'($onehot0(read_grant)), 1);
      if (write_out) begin
        if (grant_id < W) chk("data_sel", data_out, data_in[grant_id*DS +: DS]);
        else              chk("gid_range", grant_id, 0);
      end

      // Advance the model.
      if (m_busy) begin
        if (write_req[m_owner] && !ready_out && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (e_xfer && m_words < MB) m_words++;
        if (!enable[m_owner] || (!hold_req[m_owner] && (!write_req[m_owner] || m_words >= MB))) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end else begin
        for (int d = 1; d <= W; d++) begin
          int c;
          c = (m_last + d) % W;
          if (enable[c] && write_req[c]) begin
            m_owner = c;
            m_busy  = 1'b1;
            m_words = 0;
            break;
          end
        end
      end
    end

    if (log_en && busy) busy_seen++;
    if (log_en && write_out && n_tr < 64) begin
      tr_cyc[n_tr] = cyc_cnt;
      tr_id[n_tr]  = int'(grant_id);
      tr_dat[n_tr] = data_out;
      $display("xfer cycle %0d id %0d data %0d", cyc_cnt, grant_id, data_out);
      n_tr++;
    end
    pop_mask = read_grant;
    cyc_cnt++;
  end

  task automatic fifo_clear();
    for (int k = 0; k < W; k++) begin
      fhead[k] = 0;
      ftail[k] = 0;
    end
  endtask

  task automatic fifo_load(input int k, input int n);
    for (int j = 0; j < n; j++) begin
      if (ftail[k] < 64) begin
        fmem[k][ftail[k]] = 32'(k * 1000 + ftail[k]);
        ftail[k]++;
      end
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < W; k++) begin
      write_req[k] = (fhead[k] < ftail[k]);
      data_in[k*DS +: DS] = (fhead[k] < ftail[k]) ? fmem[k][fhead[k]] : 32'd0;
    end
  endtask

  task automatic rand_drive();
    write_req = W'($urandom);
    enable    = W'($urandom | $urandom);
    hold_req  = W'($urandom & $urandom & $urandom);
    ready_out = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < W; k++) data_in[k*DS +: DS] = $urandom;
  endtask

  // One clock.
  // Inputs for the next negedge are settled 1 time unit after the posedge.
  task automatic step();
    @(posedge clk);
    #1;
    if (fifo_mode) begin
      for (int k = 0; k < W; k++) begin
        if (pop_mask[k] && fhead[k] < ftail[k]) fhead[k]++;
      end
      refresh();
    end else begin
      rand_drive();
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    fifo_mode = 1'b1;
    fifo_clear();
    hold_req  = '0;
    enable    = '1;
    ready_out = 1'b1;
    refresh();
    repeat (2) step();
    rst_n     = 1'b1;
    n_tr      = 0;
    busy_seen = 0;
    log_en    = 1'b1;
  endtask

  int t0;
  int t1;
  int exp_id;

  initial begin
    rst_n     = 1'b0;
    enable    = '1;
    hold_req  = '0;
    write_req = '0;
    data_in   = '0;
    ready_out = 1'b1;
    fifo_clear();

    // Requesters 1 and 2 with 10 words each alternate in 4-word bursts,
    // with one idle cycle between grants.
    do_reset();
    fifo_load(1, 10);
    fifo_load(2, 10);
    refresh();
    t0 = cyc_cnt;
    repeat (32) step();
    chk("s1_count", n_tr, 20);
    for (int i = 0; i < 16; i++) begin
      exp_id = ((i / 4) % 2 == 0) ? 1 : 2;
      chk("s1_cyc",  tr_cyc[i], t0 + 1 + i + i / 4);
      chk("s1_id",   tr_id[i], exp_id);
      chk("s1_data", tr_dat[i], exp_id * 1000 + (i / 8) * 4 + i % 4);
    end
    chk("s1_cyc16", tr_cyc[16], t0 + 21);
    chk("s1_dat17", tr_dat[17], 1009);
    chk("s1_cyc18", tr_cyc[18], t0 + 25);
    chk("s1_dat19", tr_dat[19], 2009);

    // Requester 0 holds through 21 transfers while requester 3 waits.
    // Hold falls while the burst count is saturated, which releases the grant.
    do_reset();
    fifo_load(0, 24);
    fifo_load(3, 3);
    refresh();
    t0 = cyc_cnt;
    while (cyc_cnt < t0 + 40) begin
      hold_req = (cyc_cnt < t0 + 21) ? 5'b00001 : 5'b00000;
      step();
    end
    chk("s2_count", n_tr, 27);
    for (int i = 0; i < 21; i++) begin
      chk("s2_cyc",  tr_cyc[i], t0 + 1 + i);
      chk("s2_id",   tr_id[i], 0);
      chk("s2_data", tr_dat[i], i);
    end
    for (int i = 21; i < 24; i++) begin
      chk("s2_cyc3",  tr_cyc[i], t0 + 23 + (i - 21));
      chk("s2_id3",   tr_id[i], 3);
      chk("s2_data3", tr_dat[i], 3000 + (i - 21));
    end
    chk("s2_back0", tr_cyc[24], t0 + 28);
    chk("s2_back0_data", tr_dat[24], 21);

    // READY_OUT low for 5 cycles after the second word.
    do_reset();
    fifo_load(2, 10);
    refresh();
    t0 = cyc_cnt;
    while (cyc_cnt < t0 + 14) begin
      ready_out = !(cyc_cnt >= t0 + 3 && cyc_cnt <= t0 + 7);
      step();
    end
    ready_out = 1'b1;
    chk("s3_count", n_tr, 7);
    chk("s3_cyc0", tr_cyc[0], t0 + 1);
    chk("s3_cyc1", tr_cyc[1], t0 + 2);
    chk("s3_cyc2", tr_cyc[2], t0 + 8);
    chk("s3_cyc3", tr_cyc[3], t0 + 9);
    chk("s3_dat3", tr_dat[3], 2003);
    chk("s3_regrant", tr_cyc[4], t0 + 11);
`ifdef BURST_ARB_STALL_CNT_EN
    chk("s3_stall", stall_cnt, 5);
`endif

    // Only the disabled requester 0 is requesting.
    do_reset();
    enable = 5'b11110;
    fifo_load(0, 5);
    refresh();
    repeat (12) step();
    chk("s4_count", n_tr, 0);
    chk("s4_busy", busy_seen, 0);
    enable = '1;

    // Reset during the third word of a burst, then requester 0 wins first.
    do_reset();
    fifo_load(1, 10);
    refresh();
    t0 = cyc_cnt;
    while (cyc_cnt < t0 + 3) step();
    rst_n = 1'b0;
    #1;
    chk("s5_grant_rst", read_grant, 0);
    chk("s5_busy_rst", busy, 0);
    fifo_load(0, 4);
    refresh();
    repeat (2) step();
    rst_n = 1'b1;
    t1 = cyc_cnt;
    repeat (6) step();
    chk("s5_pre_count", tr_cyc[1], t0 + 2);
    chk("s5_first_id", tr_id[2], 0);
    chk("s5_first_cyc", tr_cyc[2], t1 + 1);
    chk("s5_first_dat", tr_dat[2], 0);

    // Random traffic, checked by the model every cycle.
    do_reset();
    log_en    = 1'b0;
    fifo_mode = 1'b0;
    rand_drive();
    repeat (10000) step();
    fifo_mode = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
